// File: rtl/edge_event_pkg.sv
// Shared types and the round-robin pick for the edge event arbiter.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package edge_event_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } evt_state_e;

    // Widest supported channel count and the ID width that covers it.
    localparam int MAX_CH   = 32;
    localparam int MAX_ID_W = 5;

    // Returns the first set bit of pend searching upward from last_id+1,
    // wrapping at num_ch. Returns 0 when nothing is pending; callers only
    // use the result when |pend is true.
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [MAX_CH-1:0]   pend,
        input logic [MAX_ID_W-1:0] last_id,
        input int                  num_ch
    );
        logic [MAX_ID_W-1:0] win;
        logic                found;
        int                  idx;
        logic [MAX_ID_W-1:0] idx_w;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx   = (int'(last_id) + k) % num_ch;
            idx_w = idx[MAX_ID_W-1:0];
            if ((k <= num_ch) && !found && pend[idx_w]) begin
                win   = idx_w;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/edge_event_if.sv
// Valid/ready event port carrying a channel ID from arbiter to consumer.
// Latency: none (wiring only).
// Backpressure: consumer holds evt_ready low; the producer keeps evt_id stable.
interface edge_event_if #(
    parameter int ID_W = 2
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;

    modport master (output evt_valid, output evt_id, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_id, output evt_ready);
endinterface

// File: rtl/edge_event_latch.sv
// Per-channel rising-edge detector with a pending flag and sticky overflow.
// Latency: rise sampled in cycle n shows on o_pend / o_ovf in cycle n+1.
// Backpressure: a rise on an already pending, unloaded channel merges and flags overflow.
module edge_event_latch (
    input  logic clk,
    input  logic resetn,
    input  logic i_din,
    input  logic i_en,
    input  logic i_load,
    input  logic i_ovf_clr,
    output logic o_pend,
    output logic o_ovf
);

    logic r_din_q;
    logic r_pend;
    logic r_ovf;
    logic w_rise;
    logic w_ovf_set;

    assign w_rise    = i_din & ~r_din_q;
    // A rise coinciding with the load is a fresh event, not a merged one.
    assign w_ovf_set = i_en & w_rise & r_pend & ~i_load;

    // Previous input level; starts high so a level already up at reset release is not an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_din_q <= 1'b1;
        else         r_din_q <= i_din;
    end

    // Pending flag: disable wins, then a new rise, then the load that consumes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      r_pend <= 1'b0;
        else if (!i_en)   r_pend <= 1'b0;
        else if (w_rise)  r_pend <= 1'b1;
        else if (i_load)  r_pend <= 1'b0;
    end

    // Sticky overflow; a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        r_ovf <= 1'b0;
        else if (w_ovf_set) r_ovf <= 1'b1;
        else if (i_ovf_clr) r_ovf <= 1'b0;
    end

    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects rising edges on NUM_CH inputs and serialises them round-robin onto one event port.
// Latency: 2 cycles from a sampled rise to evt_valid when the arbiter is idle.
// Backpressure: evt_ready low holds the offered ID; further edges queue as pending or merge as overflow.
module edge_event_arbiter
    import edge_event_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] din,
    input  logic [NUM_CH-1:0] en,
    edge_event_if.master      evt,
    output logic [NUM_CH-1:0] evt_ovf,
    input  logic              ovf_clr
);

    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_CH - 1);

    evt_state_e          r_state;
    evt_state_e          w_state_nxt;
    logic [ID_W-1:0]     r_evt_id;
    logic [ID_W-1:0]     r_last_id;
    logic [NUM_CH-1:0]   w_pend;
    logic [NUM_CH-1:0]   w_load;
    logic                w_do_load;
    logic                w_accept;
    logic [ID_W-1:0]     w_win;
    logic [MAX_CH-1:0]   w_pend_ext;
    logic [MAX_ID_W-1:0] w_last_ext;
    logic [MAX_ID_W-1:0] w_win_ext;

    // One edge latch per input channel.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        edge_event_latch u_latch (
            .clk       (clk),
            .resetn    (resetn),
            .i_din     (din[gi]),
            .i_en      (en[gi]),
            .i_load    (w_load[gi]),
            .i_ovf_clr (ovf_clr),
            .o_pend    (w_pend[gi]),
            .o_ovf     (evt_ovf[gi])
        );
    end

    // Widen pend and the pointer to the shared pick function's fixed width.
    always_comb begin
        w_pend_ext               = '0;
        w_pend_ext[NUM_CH-1:0]   = w_pend;
        w_last_ext               = '0;
        w_last_ext[ID_W-1:0]     = r_last_id;
    end

    assign w_win_ext = rr_pick(w_pend_ext, w_last_ext, NUM_CH);
    assign w_win     = w_win_ext[ID_W-1:0];

    // Next state and load decision; pend is the registered value, so a rise in
    // the accept cycle becomes eligible only on the following cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_do_load   = 1'b0;
        w_accept    = (r_state == OFFER) && evt.evt_ready;
        case (r_state)
            IDLE: begin
                if (|w_pend) begin
                    w_do_load   = 1'b1;
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (w_accept) begin
                    if (|w_pend) w_do_load   = 1'b1;
                    else         w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // One-hot load strobe back to the winning channel's latch.
    always_comb begin
        w_load = '0;
        if (w_do_load) w_load[w_win] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Output slot and round-robin pointer both follow the winner on each load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_evt_id  <= '0;
            r_last_id <= LAST_RST;
        end else if (w_do_load) begin
            r_evt_id  <= w_win;
            r_last_id <= w_win;
        end
    end

    assign evt.evt_valid = (r_state == OFFER);
    assign evt.evt_id    = r_evt_id;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus random traffic against a reference model.
// Latency: model tracks each clock; outputs are compared on the falling edge.
// Backpressure: evt_ready is driven both held-low and randomly.
module tb_edge_event_arbiter;

    localparam int N = 4;

    logic         clk     = 1'b0;
    logic         resetn  = 1'b1;
    logic [N-1:0] din     = '0;
    logic [N-1:0] en      = '0;
    logic         ovf_clr = 1'b0;
    logic [N-1:0] evt_ovf;

    edge_event_if #(.ID_W(2)) evt_if ();

    edge_event_arbiter #(.NUM_CH(N)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .din     (din),
        .en      (en),
        .evt     (evt_if),
        .evt_ovf (evt_ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the block should hold, in terms of events not circuits.
    logic [N-1:0] m_dinq;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovf;
    logic         m_valid;
    int           m_id;
    int           m_last;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dinq  = '1;
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 1'b0;
        m_id    = 0;
        m_last  = N - 1;
    endtask

    // One clock of event bookkeeping using the inputs present at this edge.
    task automatic model_step();
        logic [N-1:0] rise;
        logic [N-1:0] np;
        bit           accept;
        bit           can_load;
        int           ld;
        rise     = din & ~m_dinq;
        accept   = m_valid && evt_if.evt_ready;
        can_load = !m_valid || accept;
        ld       = -1;
        if (can_load) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (ld < 0 && m_pend[c]) ld = c;
            end
        end
        np = m_pend;
        for (int i = 0; i < N; i++) begin
            bit merged;
            merged = en[i] && rise[i] && m_pend[i] && (i != ld);
            if (!en[i])        np[i] = 1'b0;
            else if (rise[i])  np[i] = 1'b1;
            else if (i == ld)  np[i] = 1'b0;
            if (merged)        m_ovf[i] = 1'b1;
            else if (ovf_clr)  m_ovf[i] = 1'b0;
        end
        m_pend = np;
        if (ld >= 0) begin
            m_valid = 1'b1;
            m_id    = ld;
            m_last  = ld;
        end else if (accept) begin
            m_valid = 1'b0;
        end
        m_dinq = din;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("evt_valid", evt_if.evt_valid, m_valid);
        if (m_valid) chk("evt_id", evt_if.evt_id, m_id);
        chk("evt_ovf", evt_ovf, m_ovf);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop without a clock.
    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", evt_if.evt_valid, 1'b0);
        chk("rst_ovf", evt_ovf, '0);
        chk("rst_id", evt_if.evt_id, '0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic fair_round();
        din = 4'b1011;
        tick();
        din = 4'b0000;
        chk("fair_pend", evt_if.evt_valid, 1'b0);
        tick(); chk("fair_v0", evt_if.evt_valid, 1'b1); chk("fair_id0", evt_if.evt_id, 2'd0);
        tick(); chk("fair_v1", evt_if.evt_valid, 1'b1); chk("fair_id1", evt_if.evt_id, 2'd1);
        tick(); chk("fair_v3", evt_if.evt_valid, 1'b1); chk("fair_id3", evt_if.evt_id, 2'd3);
        tick(); chk("fair_done", evt_if.evt_valid, 1'b0);
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        en  = 4'hF;
        din = 4'h0;
        do_reset();

        // Single edge on channel 2: offered exactly two cycles after the sampled rise.
        repeat (4) tick();
        din[2] = 1'b1;
        tick();
        chk("single_n1", evt_if.evt_valid, 1'b0);
        tick();
        chk("single_n2_v", evt_if.evt_valid, 1'b1);
        chk("single_n2_id", evt_if.evt_id, 2'd2);
        tick();
        chk("single_n3_v", evt_if.evt_valid, 1'b0);
        chk("single_ovf", evt_ovf, 4'h0);

        // Fairness from a fresh pointer, then repeated.
        din = 4'h0;
        do_reset();
        tick();
        fair_round();
        fair_round();

        // Backpressure with a merged edge on channel 1, then clear.
        evt_if.evt_ready = 1'b0;
        din = 4'b0011; tick();
        din = 4'b0000; tick();
        chk("bp_v", evt_if.evt_valid, 1'b1);
        chk("bp_id", evt_if.evt_id, 2'd0);
        din = 4'b0010; tick();
        chk("bp_ovf_set", evt_ovf, 4'b0010);
        din = 4'b0000; tick();
        chk("bp_id_hold", evt_if.evt_id, 2'd0);
        chk("bp_ovf_hold", evt_ovf, 4'b0010);
        ovf_clr = 1'b1; tick();
        ovf_clr = 1'b0;
        chk("bp_ovf_clr", evt_ovf, 4'h0);
        evt_if.evt_ready = 1'b1; tick();
        chk("bp_next_id", evt_if.evt_id, 2'd1);
        tick();
        chk("bp_drain", evt_if.evt_valid, 1'b0);

        // Rise on channel 0 in the very cycle channel 0 is loaded.
        evt_if.evt_ready = 1'b0;
        din = 4'b0010; tick();
        din = 4'b0000; tick();
        chk("lc_hold_id", evt_if.evt_id, 2'd1);
        din = 4'b0001; tick();
        din = 4'b0000; tick();
        evt_if.evt_ready = 1'b1;
        din = 4'b0001; tick();
        chk("lc_first_id", evt_if.evt_id, 2'd0);
        chk("lc_no_ovf", evt_ovf, 4'h0);
        din = 4'b0000; tick();
        chk("lc_second_v", evt_if.evt_valid, 1'b1);
        chk("lc_second_id", evt_if.evt_id, 2'd0);
        tick();
        chk("lc_done", evt_if.evt_valid, 1'b0);

        // Enable masking: a pending ch2 event is dropped by a one-cycle disable.
        evt_if.evt_ready = 1'b0;
        din = 4'b0001; tick();
        din = 4'b0000; tick();
        din = 4'b0100; tick();
        din = 4'b0000; en = 4'b1011; tick();
        en = 4'hF; evt_if.evt_ready = 1'b1; tick();
        chk("mask_drop_a", evt_if.evt_valid, 1'b0);
        tick();
        chk("mask_drop_b", evt_if.evt_valid, 1'b0);
        en = 4'b1011;
        din = 4'b0100; tick();
        din = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mask_ignore", evt_if.evt_valid, 1'b0);
        end
        en = 4'hF;

        // Levels already high through reset give no events.
        din = 4'hF;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_high_quiet", evt_if.evt_valid, 1'b0);
        end

        // Reset in the middle of an offer with overflow set.
        din = 4'h0; tick();
        evt_if.evt_ready = 1'b0;
        din = 4'b0011; tick();
        din = 4'b0000; tick();
        chk("mid_offer_v", evt_if.evt_valid, 1'b1);
        din = 4'b0010; tick();
        chk("mid_offer_ovf", evt_ovf, 4'b0010);
        do_reset();
        din = 4'h0;
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_quiet", evt_if.evt_valid, 1'b0);
        end

        // Random traffic against the model.
        for (int t = 0; t < 3000; t++) begin
            din              = N'($urandom);
            en               = ($urandom_range(0, 7) == 0) ? N'($urandom) : 4'hF;
            evt_if.evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr          = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
